temp_conv_seq: RTL
==================

Name: temp_conv_seq

Overview:
- Sequential controller for the temperature display path. Captures one 16-bit DS18B20-format sample and scales it by 625 (0.0625 °C/LSB).
- Converts the result to BCD with a serial double-dabble engine, 21 iterations, instead of combinational divide/modulo.
- Emits the 24-bit seven-segment word with a valid strobe.
- Drives the over-temperature alarm `en` with hysteresis and consecutive-sample qualification.
- Sits between the sensor read FSM (t_data/t_valid) and the display scan logic.

Parameters:
- NEG_TWOS, 1, 1: negative samples (bit 11 set) are two's-complement negated before scaling. 0: bits [10:0] are used raw as the magnitude.
- ALARM_ON, 28, integer °C at or above which a conversion counts as "hot".
- ALARM_OFF, 26, integer °C below which `en` clears. Must satisfy ALARM_OFF <= ALARM_ON.
- ALARM_CNT, 2, consecutive hot conversions required to set `en`. Range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- t_data  input  16  raw sensor word; bit 11 = sign, [10:0] = value
- t_valid  input  1  one-cycle strobe; t_data is valid in that cycle
- busy  output  1  conversion in progress
- t_drop  output  1  one-cycle pulse when t_valid arrives while busy
- dis_data  output  24  {sign, tens, units, 0.1, 0.01, 0.001} nibbles; sign = 4'hA (+) or 4'hB (−)
- dis_valid  output  1  one-cycle strobe; dis_data updated in the same cycle
- en  output  1  over-temperature alarm, level

Behaviour:
- Reset values: busy=0, t_drop=0, dis_data=24'hA00000, dis_valid=0, en=0. FSM=IDLE, hot counter=0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - On t_valid=1, register sign = t_data[11].
  - mag = (NEG_TWOS && sign) ? (~t_data[10:0]+1) & 11'h7FF : t_data[10:0].
  - Load a 21-bit shift register with mag*625 (max 1279375, fits 21 bits). Clear the 28-bit BCD accumulator (7 digits). Iteration counter=0. Go to CONV.
- CONV: one double-dabble iteration per clock.
  - Add 3 to every BCD digit >= 5.
  - Then shift {bcd, bin} left by one.
  - After 21 iterations go to DONE.
- DONE, one cycle:
  - BCD digits are d6..d0. dis_data <= {sign?4'hB:4'hA, d5, d4, d3, d2, d1}. d0 (0.0001) and d6 (hundreds) are discarded.
  - dis_valid=1 this cycle. Apply the alarm update. Go to IDLE.
- Latency:
  - t_valid sampled at edge E0; dis_valid is high in the cycle following edge E0+22.
  - busy is high from after E0 through the dis_valid cycle inclusive.
  - A back-to-back t_valid is accepted in the cycle after dis_valid.
- t_valid while busy: the sample is ignored and t_drop pulses for one cycle. The conversion in progress is unaffected.
- Alarm update, once per DONE:
  - T = d5*10 + d4.
  - hot = !sign && T >= ALARM_ON. Hot counter increments (saturating at ALARM_CNT) when hot, clears otherwise.
  - en sets when the counter reaches ALARM_CNT.
  - en clears when sign=1 or T < ALARM_OFF.
  - Otherwise en holds (hysteresis band).
  - en changes only in DONE cycles.
- Reset mid-conversion: the next state is IDLE with all reset values. No dis_valid is produced for the aborted sample.
- dis_data holds its last value between conversions.

Test Plan:
- Reset, then t_valid with t_data=16'h01B0 -> dis_valid 23 cycles later; dis_data=24'hA27000; busy high 23 cycles; en=0.
- t_data=16'hFF5E with NEG_TWOS=1 -> dis_data=24'hB10125 (−10.125 °C); en stays 0.
- t_data=16'h07FF -> dis_data=24'hA27937, hundreds digit truncated. Second t_valid sent 5 cycles after the first -> t_drop pulse, single dis_valid, data unchanged.
- Alarm sequence, ALARM_CNT=2:
  - 16'h01C5 (28.3125 °C) -> en=0.
  - 16'h01C5 again -> en=1 at the 2nd dis_valid.
  - 16'h01B0 (27 °C) -> en=1 (held in band).
  - 16'h0190 (25 °C) -> en=0.
- Alarm counter clears on a cool sample: 16'h01C5, 16'h01B0, 16'h01C5 -> en remains 0 throughout.
- rst asserted 10 cycles into a conversion -> busy=0 and dis_data=24'hA00000 next cycle; no dis_valid; the next t_valid converts normally.

Source files
------------

// File: rtl/temp_conv_seq.sv
// Temperature display controller: scales a DS18B20 sample by 625, converts it to BCD
// with a serial double-dabble engine, and drives a hysteresis-qualified over-temperature alarm.
module temp_conv_seq #(
  parameter bit NEG_TWOS  = 1'b1,
  parameter int ALARM_ON  = 28,
  parameter int ALARM_OFF = 26,
  parameter int ALARM_CNT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] t_data,
  input  logic        t_valid,
  output logic        busy,
  output logic        t_drop,
  output logic [23:0] dis_data,
  output logic        dis_valid,
  output logic        en,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_MAX  = 4'(ALARM_CNT);
  localparam logic [4:0] LAST_ITER = 5'd20;

  state_t      state_q;
  logic        sign_q;
  logic [20:0] bin_q, bin_d;
  logic [27:0] bcd_q, bcd_d;
  logic [4:0]  iter_q;
  logic [3:0]  hot_cnt_q, hot_cnt_d;
  logic        en_d;

  logic [10:0] mag;
  logic [20:0] scaled;
  logic [27:0] bcd_adj;
  logic [6:0]  temp_int;
  logic        hot;
  logic        unused_bits;

  assign unused_bits = ^t_data[15:12];
  assign dbg_state   = state_q;

  always_comb begin
    mag    = (NEG_TWOS && t_data[11]) ? (~t_data[10:0] + 11'd1) : t_data[10:0];
    scaled = 21'(mag) * 21'd625;

    // Double-dabble step: pre-correct every digit >= 5, then shift {bcd, bin} left by one.
    bcd_adj = '0;
    for (int i = 0; i < 7; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcd_d = {bcd_adj[26:0], bin_q[20]};
    bin_d = {bin_q[19:0], 1'b0};

    // Integer degrees come from the tens and units digits; hundreds are not displayed.
    temp_int  = 7'(bcd_q[23:20]) * 7'd10 + 7'(bcd_q[19:16]);
    hot       = !sign_q && (int'(temp_int) >= ALARM_ON);
    hot_cnt_d = !hot ? 4'd0 : (hot_cnt_q == CNT_MAX) ? hot_cnt_q : hot_cnt_q + 4'd1;

    en_d = en;
    if (hot_cnt_d == CNT_MAX) begin
      en_d = 1'b1;
    end else if (sign_q || int'(temp_int) < ALARM_OFF) begin
      en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      hot_cnt_q <= '0;
      busy      <= 1'b0;
      t_drop    <= 1'b0;
      dis_data  <= 24'hA00000;
      dis_valid <= 1'b0;
      en        <= 1'b0;
    end else begin
      t_drop    <= 1'b0;
      dis_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (t_valid) begin
            // The dis_valid cycle still counts as busy, so a sample there is dropped.
            if (dis_valid) begin
              t_drop <= 1'b1;
              busy   <= 1'b0;
            end else begin
              sign_q  <= t_data[11];
              bin_q   <= scaled;
              bcd_q   <= '0;
              iter_q  <= '0;
              busy    <= 1'b1;
              state_q <= CONV;
            end
          end
        end
        CONV: begin
          if (t_valid) t_drop <= 1'b1;
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          iter_q <= iter_q + 5'd1;
          if (iter_q == LAST_ITER) state_q <= DONE;
        end
        DONE: begin
          if (t_valid) t_drop <= 1'b1;
          dis_data  <= {(sign_q ? 4'hB : 4'hA), bcd_q[23:4]};
          dis_valid <= 1'b1;
          hot_cnt_q <= hot_cnt_d;
          en        <= en_d;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
